// File: rtl/eth_flood_gen_pkg.sv
// Shared types for the UDP flood generator: latched run config, header
// layout overlaid on the 64-bit beat grid, and last-beat keep helper.
package flood_pkg;
  localparam int HDR_BEATS = 6;

  typedef enum logic [2:0] {ST_IDLE, ST_PREP0, ST_PREP1, ST_SEND, ST_GAP} state_e;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] ifg;
    logic [31:0] burst;
    logic [15:0] dport_lo;
    logic [15:0] dport_hi;
    logic [15:0] dport;
    logic [31:0] saddr;
    logic [15:0] saddr_cnt;
  } flood_cfg_t;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
  } ethhdr_t;

  typedef struct packed {
    logic [7:0]  ver_ihl;
    logic [7:0]  tos;
    logic [15:0] tot_len;
    logic [15:0] id;
    logic [15:0] frag;
    logic [7:0]  ttl;
    logic [7:0]  proto;
    logic [15:0] check;
    logic [31:0] saddr;
    logic [31:0] daddr;
  } iphdr_t;

  typedef struct packed {
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] len;
    logic [15:0] check;
  } udphdr_t;

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] flags;
  } dnshdr_t;

  typedef struct packed {
    ethhdr_t     eth;
    iphdr_t      ip;
    udphdr_t     udp;
    dnshdr_t     dns;
    logic [15:0] pad;
  } frame_hdr_t;

  // Byte 0 of the frame sits in the MSB, so beat[HDR_BEATS-1][7] is wire byte 0.
  typedef union packed {
    frame_hdr_t                          f;
    logic [HDR_BEATS-1:0][7:0][7:0]      beat;
  } hdr_u;

  function automatic logic [7:0] tkeep_from_len(input logic [2:0] rem);
    return (rem == 3'd0) ? 8'hFF : 8'(8'hFF >> (4'd8 - {1'b0, rem}));
  endfunction
endpackage

// File: rtl/eth_flood_gen_if.sv
// AXI-Stream TX bus between the flood generator and the 10G MAC.
interface eth_flood_gen_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_flood_gen_csum.sv
// Two-stage IPv4 header checksum: stage 1 sums the ten header words,
// stage 2 folds twice and inverts. vld_o holds until the next frame starts.
module ip_csum16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [31:0] saddr_i,
  input  logic [31:0] daddr_i,
  input  logic [15:0] tot_len_i,
  output logic [15:0] csum_o,
  output logic        vld_o
);
  logic [19:0] sum_q, sum_d;
  logic [15:0] csum_q;
  logic [16:0] f1;
  logic [15:0] f2;
  logic [1:0]  vld_pipe_q;

  // Constant words: 0x4500 (ver/ihl/tos), 0x4011 (ttl 64, proto UDP); id/frag/check are 0.
  always_comb begin
    sum_d = 20'h04500 + 20'(tot_len_i) + 20'h04011
          + 20'(saddr_i[31:16]) + 20'(saddr_i[15:0])
          + 20'(daddr_i[31:16]) + 20'(daddr_i[15:0]);
    f1 = 17'(sum_q[15:0]) + 17'(sum_q[19:16]);
    f2 = f1[15:0] + {15'h0, f1[16]};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum_q      <= '0;
      csum_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      if (en_i) sum_q <= sum_d;
      if (vld_pipe_q[0]) csum_q <= ~f2;
      vld_pipe_q[0] <= en_i;
      vld_pipe_q[1] <= en_i ? 1'b0 : (vld_pipe_q[0] | vld_pipe_q[1]);
    end

  assign csum_o = csum_q;
  assign vld_o  = vld_pipe_q[1];
endmodule

// File: rtl/eth_flood_gen.sv
// Configurable DNS-response UDP flood source for the 10G MAC TX AXI-Stream.
// Define ETH_FLOOD_STATS_EN to add saturating frame/byte/stall counters.
module eth_flood_gen
  import flood_pkg::*;
#(
  parameter logic [47:0] ETH_DST   = 48'h90_E2_BA_5D_8D_C8,
  parameter logic [47:0] ETH_SRC   = 48'h00_BB_00_BB_00_BB,
  parameter logic [31:0] IP_DADDR  = 32'h0A000001,
  parameter logic [15:0] UDP_SPORT = 16'd53,
  parameter logic [15:0] MIN_LEN   = 16'd60,
  parameter logic [15:0] MAX_LEN   = 16'd1514
) (
  input  logic              clk156,
  input  logic              sys_rst_n,
  input  logic              cfg_enable,
  input  logic [15:0]       cfg_frame_len,
  input  logic [15:0]       cfg_ifg,
  input  logic [31:0]       cfg_burst,
  input  logic [15:0]       cfg_dport_lo,
  input  logic [15:0]       cfg_dport_hi,
  input  logic [31:0]       cfg_saddr_base,
  input  logic [15:0]       cfg_saddr_cnt,
  eth_flood_gen_if.master   s_axis_tx,
  output logic              busy,
  output logic              done
`ifdef ETH_FLOOD_STATS_EN
  ,
  output logic [31:0]       stat_frames,
  output logic [47:0]       stat_bytes,
  output logic [31:0]       stat_stall
`endif
);
  state_e      state_q, state_d;
  flood_cfg_t  cfg_q;
  logic [7:0]  beat_q;
  logic [15:0] gap_q, dport_q, sidx_q;
  logic [31:0] fcnt_q;
  logic        done_q, done_d;

  logic [15:0] len_c, dport_c, cnt_eff, sidx_nx, dport_nx;
  logic [31:0] saddr_c;
  logic        send, hs, last, hs_last, burst_hit;
  logic [15:0] csum;
  logic        csum_vld;
  hdr_u        hdr;
  logic [63:0] data_c;
  logic [2:0]  hb;

  // A stale dport outside the current range (including the reset value) restarts at lo.
  always_comb begin
    len_c   = (cfg_frame_len < MIN_LEN) ? MIN_LEN :
              (cfg_frame_len > MAX_LEN) ? MAX_LEN : cfg_frame_len;
    dport_c = (cfg_dport_lo >= cfg_dport_hi || dport_q < cfg_dport_lo || dport_q > cfg_dport_hi)
              ? cfg_dport_lo : dport_q;
    saddr_c = cfg_saddr_base + {16'h0, sidx_q};
  end

  ip_csum16 u_csum (
    .clk(clk156), .rst_n(sys_rst_n), .en_i(state_q == ST_PREP0),
    .saddr_i(saddr_c), .daddr_i(IP_DADDR), .tot_len_i(len_c - 16'd14),
    .csum_o(csum), .vld_o(csum_vld)
  );

  always_comb begin
    send      = (state_q == ST_SEND);
    hs        = send & s_axis_tx.tready;
    last      = ({8'h0, beat_q} == ((cfg_q.len - 16'd1) >> 3));
    hs_last   = hs & last;
    burst_hit = (cfg_q.burst != 32'd0) && (fcnt_q + 32'd1 == cfg_q.burst);
    cnt_eff   = (cfg_q.saddr_cnt == 16'd0) ? 16'd1 : cfg_q.saddr_cnt;
    sidx_nx   = (sidx_q + 16'd1 >= cnt_eff) ? 16'd0 : sidx_q + 16'd1;
    dport_nx  = (cfg_q.dport_lo >= cfg_q.dport_hi || cfg_q.dport == cfg_q.dport_hi)
                ? cfg_q.dport_lo : cfg_q.dport + 16'd1;
  end

  // Burst completion wins over an enable drop on the same final beat.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (cfg_enable) state_d = ST_PREP0;
      ST_PREP0: state_d = cfg_enable ? ST_PREP1 : ST_IDLE;
      ST_PREP1: state_d = cfg_enable ? ST_SEND : ST_IDLE;
      ST_SEND:
        if (hs_last) begin
          done_d = burst_hit;
          if (burst_hit || !cfg_enable)   state_d = ST_IDLE;
          else if (cfg_q.ifg == 16'd0)    state_d = ST_PREP0;
          else                            state_d = ST_GAP;
        end
      ST_GAP:
        if (!cfg_enable)                          state_d = ST_IDLE;
        else if (gap_q == cfg_q.ifg - 16'd1)      state_d = ST_PREP0;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk156 or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      dport_q <= '0;
      sidx_q  <= '0;
      fcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == ST_PREP0)
        cfg_q <= '{len: len_c, ifg: cfg_ifg, burst: cfg_burst, dport_lo: cfg_dport_lo,
                   dport_hi: cfg_dport_hi, dport: dport_c, saddr: saddr_c,
                   saddr_cnt: cfg_saddr_cnt};
      if (hs) beat_q <= hs_last ? 8'd0 : beat_q + 8'd1;
      gap_q <= (state_q == ST_GAP) ? gap_q + 16'd1 : 16'd0;
      if (hs_last) begin
        dport_q <= dport_nx;
        sidx_q  <= sidx_nx;
      end
      fcnt_q <= (state_d == ST_IDLE) ? 32'd0 : (hs_last ? fcnt_q + 32'd1 : fcnt_q);
    end

  always_comb begin
    hdr.f = '{
      eth: '{dst: ETH_DST, src: ETH_SRC, etype: 16'h0800},
      ip:  '{ver_ihl: 8'h45, tos: 8'h00, tot_len: cfg_q.len - 16'd14, id: 16'h0,
             frag: 16'h0, ttl: 8'h40, proto: 8'h11, check: csum_vld ? csum : 16'h0,
             saddr: cfg_q.saddr, daddr: IP_DADDR},
      udp: '{sport: UDP_SPORT, dport: cfg_q.dport, len: cfg_q.len - 16'd34, check: 16'h0},
      dns: '{id: 16'h0, flags: 16'h8000},
      pad: 16'h0
    };
    hb     = 3'(HDR_BEATS - 1) - beat_q[2:0];
    data_c = '0;
    if (beat_q < 8'(HDR_BEATS))
      for (int j = 0; j < 8; j++) data_c[8*j +: 8] = hdr.beat[hb][7-j];
  end

  // Everything below derives from registers that only move on a handshake.
  assign s_axis_tx.tvalid = send;
  assign s_axis_tx.tdata  = send ? data_c : 64'h0;
  assign s_axis_tx.tkeep  = send ? (last ? tkeep_from_len(cfg_q.len[2:0]) : 8'hFF) : 8'h0;
  assign s_axis_tx.tlast  = send & last;
  assign s_axis_tx.tuser  = 1'b0;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

`ifdef ETH_FLOOD_STATS_EN
  logic [31:0] st_frames_q, st_stall_q;
  logic [47:0] st_bytes_q;
  logic [48:0] bytes_sum;

  assign bytes_sum = {1'b0, st_bytes_q} + 49'(cfg_q.len);

  always_ff @(posedge clk156 or negedge sys_rst_n)
    if (!sys_rst_n) begin
      st_frames_q <= '0;
      st_bytes_q  <= '0;
      st_stall_q  <= '0;
    end else begin
      if (hs_last && !(&st_frames_q)) st_frames_q <= st_frames_q + 32'd1;
      if (hs_last) st_bytes_q <= bytes_sum[48] ? '1 : bytes_sum[47:0];
      if (send && !s_axis_tx.tready && !(&st_stall_q)) st_stall_q <= st_stall_q + 32'd1;
    end

  assign stat_frames = st_frames_q;
  assign stat_bytes  = st_bytes_q;
  assign stat_stall  = st_stall_q;
`endif
endmodule
